// File: rtl/unpack_pkg.sv
// ============================================================================
// unpack_pkg : shared types and bit indices for the word_unpacker block
// Rev 1.0
// ============================================================================
`default_nettype none

package unpack_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam int CTRL_ORDER = 0;
   localparam int CTRL_FLUSH = 1;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_LAST  = 3;

endpackage : unpack_pkg

`default_nettype wire

// File: rtl/word_fifo.sv
// ============================================================================
// word_fifo : synchronous word FIFO with wrap-bit pointers and clear
// Rev 1.0
// ============================================================================
`default_nettype none

module word_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_ptr_one = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra MSB distinguishes full from empty when the index bits match.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule : word_fifo

`default_nettype wire

// File: rtl/word_unpacker.sv
// ============================================================================
// word_unpacker : word-to-byte serializer behind a word FIFO
// Optional UNPACK_COUNT_EN adds a 16-bit delivered-byte counter port.
// Rev 1.0
// ============================================================================
`default_nettype none

module word_unpacker
   import unpack_pkg::*;
#(
   parameter int WORD_W     = 16,
   parameter int BYTE_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [3:0]        control,
   input  logic [WORD_W-1:0] data_in,
   input  logic              data_in_valid,
   output logic              data_in_ready,
   output logic [BYTE_W-1:0] data_out,
   output logic              valid,
   input  logic              ready,
`ifdef UNPACK_COUNT_EN
   output logic [15:0]       byte_count,
`endif
   output logic [3:0]        status
);

   localparam int RATIO = WORD_W / BYTE_W;
   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(RATIO - 1);
   localparam logic [IDX_W-1:0] c_idx_one  = {{(IDX_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   logic [WORD_W-1:0] r_word;
   logic              r_order;
   logic [IDX_W-1:0]  r_idx;
   logic [BYTE_W-1:0] r_data_out;
   logic              r_valid;
   logic              r_last;

   logic              w_flush;
   logic              w_push;
   logic              w_pop;
   logic              w_out_hs;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [WORD_W-1:0] w_head;
   logic [IDX_W-1:0]  w_idx_next;
   logic              w_unused_ctrl;

   function automatic logic [BYTE_W-1:0] sel_byte(
      input logic [WORD_W-1:0] word,
      input logic              order,
      input logic [IDX_W-1:0]  idx
   );
      int base;
      base = order ? int'(idx) * BYTE_W : WORD_W - (int'(idx) + 1) * BYTE_W;
      return word[base +: BYTE_W];
   endfunction

   assign w_flush       = control[CTRL_FLUSH];
   assign w_unused_ctrl = ^control[3:2];
   assign data_in_ready = reset && enable && !w_fifo_full && !w_flush;
   assign w_push        = data_in_valid && data_in_ready;
   assign w_out_hs      = r_valid && ready;
   assign w_idx_next    = r_idx + c_idx_one;

   // Pop on load from IDLE, or on the final byte so the next word follows without a bubble.
   always_comb begin
      w_pop = 1'b0;
      if (!w_flush) begin
         case (r_state)
            IDLE:    w_pop = !w_fifo_empty;
            SEND:    w_pop = w_out_hs && (r_idx == c_last_idx) && !w_fifo_empty;
            default: w_pop = 1'b0;
         endcase
      end
   end

   word_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_clear (w_flush),
      .i_push  (w_push),
      .i_data  (data_in),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_word     <= '0;
         r_order    <= 1'b0;
         r_idx      <= '0;
         r_data_out <= '0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
      end else if (w_flush) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_fifo_empty) begin
                  r_word     <= w_head;
                  r_order    <= control[CTRL_ORDER];
                  r_idx      <= '0;
                  r_data_out <= sel_byte(w_head, control[CTRL_ORDER], '0);
                  r_valid    <= 1'b1;
                  r_last     <= 1'b0;
                  r_state    <= SEND;
               end
            end
            SEND: begin
               if (w_out_hs) begin
                  if (r_idx != c_last_idx) begin
                     r_idx      <= w_idx_next;
                     r_data_out <= sel_byte(r_word, r_order, w_idx_next);
                     r_last     <= (w_idx_next == c_last_idx);
                  end else if (!w_fifo_empty) begin
                     r_word     <= w_head;
                     r_order    <= control[CTRL_ORDER];
                     r_idx      <= '0;
                     r_data_out <= sel_byte(w_head, control[CTRL_ORDER], '0);
                     r_last     <= 1'b0;
                  end else begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_last  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign data_out          = r_data_out;
   assign valid             = r_valid;
   assign status[ST_EMPTY]  = w_fifo_empty;
   assign status[ST_FULL]   = w_fifo_full;
   assign status[ST_BUSY]   = (r_state == SEND);
   assign status[ST_LAST]   = r_last;

`ifdef UNPACK_COUNT_EN
   logic [15:0] r_byte_count;

   // A handshake in the flush cycle is dropped along with the rest of the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_byte_count <= '0;
      end else if (w_flush) begin
         r_byte_count <= '0;
      end else if (w_out_hs) begin
         r_byte_count <= r_byte_count + 16'd1;
      end
   end

   assign byte_count = r_byte_count;
`endif

endmodule : word_unpacker

`default_nettype wire

// File: tb/tb_word_unpacker.sv
// ============================================================================
// tb_word_unpacker : scoreboard bench for word_unpacker (16-bit words, 8-bit bytes)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_word_unpacker;

   localparam int WORD_W = 16;
   localparam int BYTE_W = 8;
   localparam int RATIO  = WORD_W / BYTE_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic [3:0]        control;
   logic [WORD_W-1:0] data_in;
   logic              data_in_valid;
   logic              data_in_ready;
   logic [BYTE_W-1:0] data_out;
   logic              valid;
   logic              ready;
   logic [3:0]        status;
`ifdef UNPACK_COUNT_EN
   logic [15:0]       byte_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [BYTE_W:0] exp_q [$];

   always #5 clk = ~clk;

   word_unpacker #(
      .WORD_W     (WORD_W),
      .BYTE_W     (BYTE_W),
      .FIFO_DEPTH (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .control       (control),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_ready (data_in_ready),
      .data_out      (data_out),
      .valid         (valid),
      .ready         (ready),
`ifdef UNPACK_COUNT_EN
      .byte_count    (byte_count),
`endif
      .status        (status)
   );

   // Settle inputs, report both handshakes and enqueue expected bytes for an accepted word.
   task automatic settle(output bit o_hs, output bit i_hs);
      logic [BYTE_W-1:0] b;
      #1;
      o_hs = valid && ready;
      i_hs = data_in_valid && data_in_ready;
      if (i_hs) begin
         for (int k = 0; k < RATIO; k++) begin
            b = control[0] ? data_in[k*BYTE_W +: BYTE_W]
                           : data_in[WORD_W-(k+1)*BYTE_W +: BYTE_W];
            exp_q.push_back({(k == RATIO-1), b});
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b1; control = '0;
      data_in = '0; data_in_valid = 1'b0; ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_out); end
      n_checks++;
      if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
      n_checks++;
      if (status !== 4'b0001) begin n_fail++; $display("FAIL reset_status: got %b want 0001", status); end
      n_checks++;
      if (data_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", data_in_ready); end
`ifdef UNPACK_COUNT_EN
      n_checks++;
      if (byte_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0000", byte_count); end
`endif
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++;
      if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", data_in_ready); end
      @(negedge clk);
   endtask

   task automatic test_enable();
      bit o, i;
      enable = 1'b0; data_in = 16'h7777; data_in_valid = 1'b1;
      settle(o, i);
      n_checks++;
      if (i !== 1'b0 || data_in_ready !== 1'b0) begin
         n_fail++; $display("FAIL enable_low: in_ready got %b want 0", data_in_ready);
      end
      data_in_valid = 1'b0; enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      bit o, i;
      logic [BYTE_W:0] e;
      control = 4'b0000; ready = 1'b1; data_in = 16'hA55A; data_in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         settle(o, i);
         if (c == 0) begin
            n_checks++;
            if (i !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b want 1", i); end
         end
         if (c == 1) begin
            n_checks++;
            if (valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: valid got %b want 0 at t+1", valid); end
         end
         if (c == 2) begin
            n_checks++;
            if ({valid, data_out, status[3]} !== {1'b1, 8'hA5, 1'b0}) begin
               n_fail++; $display("FAIL single_byte0: got v=%b d=%h last=%b want v=1 d=a5 last=0", valid, data_out, status[3]);
            end
         end
         if (c == 3) begin
            n_checks++;
            if ({valid, data_out, status[3]} !== {1'b1, 8'h5A, 1'b1}) begin
               n_fail++; $display("FAIL single_byte1: got v=%b d=%h last=%b want v=1 d=5a last=1", valid, data_out, status[3]);
            end
         end
         if (c == 4) begin
            n_checks++;
            if (valid !== 1'b0 || status !== 4'b0001) begin
               n_fail++; $display("FAIL single_idle: got v=%b status=%b want v=0 status=0001", valid, status);
            end
         end
         if (o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL single_sb: got byte %h want none", data_out);
            end else begin
               e = exp_q.pop_front();
               if ({status[3], data_out} !== e) begin
                  n_fail++; $display("FAIL single_sb: got %h last=%b want %h last=%b", data_out, status[3], e[7:0], e[8]);
               end
            end
         end
         @(negedge clk);
         data_in_valid = 1'b0;
      end
   endtask

   task automatic test_order_backpressure();
      bit o, i;
      logic [BYTE_W:0] e;
      control = 4'b0001;
      for (int c = 0; c < 14; c++) begin
         data_in_valid = (c < 2);
         data_in       = (c == 0) ? 16'h1234 : 16'hBEEF;
         ready         = (c >= 5);
         settle(o, i);
         if (c < 2) begin
            n_checks++;
            if (i !== 1'b1) begin n_fail++; $display("FAIL order_accept%0d: got %b want 1", c, i); end
         end
         if (c >= 2 && c <= 4) begin
            n_checks++;
            if ({valid, data_out, status[3]} !== {1'b1, 8'h34, 1'b0}) begin
               n_fail++; $display("FAIL order_stall%0d: got v=%b d=%h last=%b want v=1 d=34 last=0", c, valid, data_out, status[3]);
            end
         end
         if (c == 6) begin
            n_checks++;
            if ({valid, data_out, status[3]} !== {1'b1, 8'h12, 1'b1}) begin
               n_fail++; $display("FAIL order_byte1: got v=%b d=%h last=%b want v=1 d=12 last=1", valid, data_out, status[3]);
            end
         end
         if (c == 7) begin
            n_checks++;
            if ({valid, data_out} !== {1'b1, 8'hEF}) begin
               n_fail++; $display("FAIL order_no_gap: got v=%b d=%h want v=1 d=ef", valid, data_out);
            end
         end
         if (o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL order_sb: got byte %h want none", data_out);
            end else begin
               e = exp_q.pop_front();
               if ({status[3], data_out} !== e) begin
                  n_fail++; $display("FAIL order_sb: got %h last=%b want %h last=%b", data_out, status[3], e[7:0], e[8]);
               end
            end
         end
         @(negedge clk);
      end
      n_checks++;
      if (exp_q.size() != 0 || valid !== 1'b0) begin
         n_fail++; $display("FAIL order_drain: got %0d pending v=%b want 0 pending v=0", exp_q.size(), valid);
      end
   endtask

   task automatic test_full();
      bit o, i;
      logic [BYTE_W:0] e;
      logic [WORD_W-1:0] words [6];
      int pushed;
      int c;
      words = '{16'hA1B1, 16'hA2B2, 16'hA3B3, 16'hA4B4, 16'hA5B5, 16'hA6B6};
      pushed = 0;
      control = 4'b0000;
      for (c = 0; c < 60; c++) begin
         if (c > 8 && pushed == 6 && exp_q.size() == 0 && !valid) break;
         data_in_valid = (pushed < 6);
         data_in       = words[(pushed < 6) ? pushed : 0];
         ready         = (c >= 8);
         settle(o, i);
         if (i) pushed++;
         if (c == 5) begin
            n_checks++;
            if (status[1] !== 1'b1 || data_in_ready !== 1'b0 || pushed != 5) begin
               n_fail++; $display("FAIL full_flag: got full=%b in_ready=%b pushed=%0d want 1 0 5", status[1], data_in_ready, pushed);
            end
         end
         if (c == 7) begin
            n_checks++;
            if (i !== 1'b0) begin n_fail++; $display("FAIL full_stall: got accept=%b want 0", i); end
         end
         if (o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL full_sb: got byte %h want none", data_out);
            end else begin
               e = exp_q.pop_front();
               if ({status[3], data_out} !== e) begin
                  n_fail++; $display("FAIL full_sb: got %h last=%b want %h last=%b", data_out, status[3], e[7:0], e[8]);
               end
            end
         end
         @(negedge clk);
      end
      n_checks++;
      if (c >= 60 || pushed != 6 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL full_drain: got pushed=%0d pending=%0d cycles=%0d want 6 0 <60", pushed, exp_q.size(), c);
      end
      data_in_valid = 1'b0;
   endtask

   task automatic test_flush();
      bit o, i;
      logic [BYTE_W:0] e;
      for (int c = 0; c < 11; c++) begin
         control       = (c == 4) ? 4'b0010 : 4'b0000;
         ready         = (c >= 3);
         data_in_valid = (c <= 2) || (c == 4) || (c == 5);
         case (c)
            0:       data_in = 16'hCAFE;
            1:       data_in = 16'h1111;
            2:       data_in = 16'h2222;
            4:       data_in = 16'hDEAD;
            default: data_in = 16'h0102;
         endcase
         settle(o, i);
         if (c == 4) begin
            n_checks++;
            if (i !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %b want 0", i); end
         end
         if (c == 5) begin
            n_checks++;
            if (valid !== 1'b0 || status !== 4'b0001) begin
               n_fail++; $display("FAIL flush_state: got v=%b status=%b want v=0 status=0001", valid, status);
            end
         end
         if (c == 7 || c == 8) begin
            n_checks++;
            if ({valid, data_out} !== {1'b1, (c == 7) ? 8'h01 : 8'h02}) begin
               n_fail++; $display("FAIL flush_next%0d: got v=%b d=%h want v=1 d=%h", c, valid, data_out, (c == 7) ? 8'h01 : 8'h02);
            end
         end
         if (o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL flush_sb: got byte %h want none", data_out);
            end else begin
               e = exp_q.pop_front();
               if ({status[3], data_out} !== e) begin
                  n_fail++; $display("FAIL flush_sb: got %h last=%b want %h last=%b", data_out, status[3], e[7:0], e[8]);
               end
            end
         end
         if (c == 4) exp_q.delete();
         @(negedge clk);
      end
      control = 4'b0000; data_in_valid = 1'b0;
      n_checks++;
      if (exp_q.size() != 0 || valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_drain: got %0d pending v=%b want 0 pending v=0", exp_q.size(), valid);
      end
   endtask

   task automatic test_reset_mid();
      bit o, i;
      control = 4'b0000; ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         data_in = 16'h5000 + 16'(c); data_in_valid = 1'b1;
         settle(o, i);
         @(negedge clk);
      end
      data_in_valid = 1'b0;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({valid, data_out, status, data_in_ready} !== {1'b0, 8'h00, 4'b0001, 1'b0}) begin
         n_fail++; $display("FAIL reset_mid: got v=%b d=%h status=%b in_ready=%b want 0 00 0001 0", valid, data_out, status, data_in_ready);
      end
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1; ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (valid !== 1'b0 || status !== 4'b0001) begin
         n_fail++; $display("FAIL reset_mid_discard: got v=%b status=%b want v=0 status=0001", valid, status);
      end
      @(negedge clk);
   endtask

`ifdef UNPACK_COUNT_EN
   task automatic test_counter();
      bit o, i;
      int n_hs;
      int c;
      control = 4'b0010; data_in_valid = 1'b0; ready = 1'b1;
      @(negedge clk);
      control = 4'b0000;
      #1;
      n_checks++;
      if (byte_count !== 16'h0000) begin n_fail++; $display("FAIL count_flush: got %h want 0000", byte_count); end
      @(negedge clk);
      n_hs = 0;
      for (c = 0; c < 70000 && n_hs < 65538; c++) begin
         data_in_valid = 1'b1; data_in = 16'(c);
         settle(o, i);
         if (n_hs == 65535) begin
            n_checks++;
            if (byte_count !== 16'hFFFF) begin n_fail++; $display("FAIL count_ffff: got %h want ffff", byte_count); end
         end
         if (n_hs == 65536) begin
            n_checks++;
            if (byte_count !== 16'h0000) begin n_fail++; $display("FAIL count_wrap: got %h want 0000", byte_count); end
         end
         if (n_hs == 65537) begin
            n_checks++;
            if (byte_count !== 16'h0001) begin n_fail++; $display("FAIL count_after_wrap: got %h want 0001", byte_count); end
         end
         if (o) begin
            n_hs++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         @(negedge clk);
      end
      n_checks++;
      if (n_hs < 65538) begin n_fail++; $display("FAIL count_budget: got %0d bytes want 65538", n_hs); end
      data_in_valid = 1'b0;
      control = 4'b0010;
      @(negedge clk);
      control = 4'b0000;
      exp_q.delete();
      @(negedge clk);
   endtask
`endif

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time budget exhausted");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_enable();
      test_single();
      test_order_backpressure();
      test_full();
      test_flush();
      test_reset_mid();
`ifdef UNPACK_COUNT_EN
      test_counter();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_word_unpacker

`default_nettype wire
